weight_bank_dbuf: RTL and testbench
===================================

# weight_bank_dbuf

Double-buffered, parametrised weight store for the vector-multiplier array; supersedes the single-word reload register. Weights stream in one row per beat over a valid/ready handshake into a shadow bank while the active bank keeps driving the multiplier array. A swap copies the completed shadow matrix to the active bank in one cycle, so weight reload no longer stalls compute.

## Interface
- `WEIGHT_BW`, 8: signed weight width in bits.
- `LANES`, 8: weights per row (array columns).
- `DEPTH`, 8: rows per matrix; must be ≥ 2.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_valid` in 1: `load_data` holds a valid row.
- `load_ready` out 1: bank accepts a row this cycle.
- `load_data` in LANES*WEIGHT_BW: one row; lane k is bits [k*WEIGHT_BW +: WEIGHT_BW], signed.
- `load_clear` in 1: discard the partial shadow load and return the row counter to 0.
- `swap` in 1: single-cycle request to promote the shadow bank to active.
- `swap_done` out 1: one-cycle pulse in the cycle after a swap is taken.
- `shadow_full` out 1: all DEPTH rows of the shadow bank are loaded.
- `active_valid` out 1: the active bank holds a swapped-in matrix.
- `load_row` out $clog2(DEPTH): index of the next shadow row to be written.
- `weight_out` out DEPTH*LANES*WEIGHT_BW: active matrix, registered; row r lane k is bits [(r*LANES+k)*WEIGHT_BW +: WEIGHT_BW].

## Operation
- States:
  - IDLE: shadow is empty, `load_row` = 0.
  - LOAD: 1 to DEPTH-1 rows accepted.
  - FULL: DEPTH rows accepted.
- `load_ready` = 1 in IDLE and LOAD, and 0 in FULL.
- Accept: `load_valid && load_ready` at an edge.
  - Writes `load_data` into shadow row `load_row`.
  - Increments `load_row`.
  - IDLE → LOAD, or LOAD → FULL when the accepted row is DEPTH-1.
  - In FULL, `load_row` wraps to 0.
- Swap:
  - `swap` is honoured only in FULL.
  - At that edge, the active bank receives all shadow rows, the state returns to IDLE, and `active_valid` is set to 1.
  - `active_valid` stays at 1 until reset.
- A `swap` in IDLE or LOAD is ignored, with no side effects.
- `load_clear` has priority over an accept and a swap in the same cycle: state → IDLE, `load_row` → 0. The shadow contents are don't-care, and the active bank is untouched.
- Last-row accept with `swap` in the same cycle: the row is accepted and the swap is ignored, because the state was LOAD at that edge.
- The shadow bank is not cleared after a swap; new rows overwrite it.
- Values are stored bit-exact; no arithmetic is performed.

## Timing
- Reset values: all state held in IDLE, `load_ready` = 1, `load_row` = 0, `shadow_full` = 0, `active_valid` = 0, `swap_done` = 0, `weight_out` = 0. The shadow bank is cleared to 0.
- Reset mid-load or mid-swap: everything returns to the reset values immediately (asynchronous).
- `load_ready`, `shadow_full` and `load_row` are registered state decodes. They reflect an accept one cycle after its edge.
- Throughput: one row per cycle. A full load takes DEPTH cycles when `load_valid` is held high.
- Swap latency: `swap` sampled at edge N →
  - `weight_out` shows the new matrix after edge N;
  - `swap_done` is high for the cycle after edge N;
  - `load_ready` returns to 1 after edge N, so a new load may start at edge N+1.
- `weight_out` changes only on a swap edge or on reset.

## Configuration
- `WEIGHT_BANK_AUTO_SWAP_EN` defined:
  - In FULL, the swap is taken at the next edge without `swap`: last row at edge N, swap at edge N+1.
  - The `swap` input is ignored.
  - `load_clear` asserted at edge N+1 still wins, and no swap occurs.
- Not defined: the block stays in FULL indefinitely until `swap` or `load_clear`.

## Test plan
- Reset, then stream rows r = 0..7 with lane k = r*8+k (signed, 8-bit), then pulse `swap` → `weight_out` row 3 lane 5 = 29; `swap_done` is high for 1 cycle; `active_valid` = 1.
- After the first swap, load a second matrix of all -1 (0xFF) while checking `weight_out` → it stays at the first matrix until the second swap, then reads all 0xFF.
- Backpressure: hold `load_valid` = 1 for 12 cycles in FULL → exactly 8 rows accepted; `load_ready` = 0 and `shadow_full` = 1 from cycle 9.
- Pulse `swap` at `load_row` = 4, then pulse `load_clear` with `load_valid` = 1 → no swap and no `swap_done`; `load_row` = 0; the row presented with `load_clear` is dropped.
- Assert `rst` at `load_row` = 5 after a prior swap → all outputs return to their reset values, including `weight_out` = 0 and `active_valid` = 0.
- With `WEIGHT_BANK_AUTO_SWAP_EN`: last row at edge N, `swap` held low → `swap_done` is high in the cycle after edge N+1, and `weight_out` is updated.

Source files
------------

// File: rtl/weight_bank_dbuf.sv
// weight_bank_dbuf: double-buffered weight store for the vector-multiplier array.
// Rows stream into a shadow bank over a valid/ready handshake while the active
// bank keeps driving weight_out. A swap copies the whole shadow matrix into the
// active bank in one cycle.
// Optional build macro: WEIGHT_BANK_AUTO_SWAP_EN -- when defined, a full shadow
// bank is promoted automatically on the edge after the last row, and the swap
// input is ignored.
module weight_bank_dbuf #(
    parameter int WEIGHT_BW = 8,
    parameter int LANES     = 8,
    parameter int DEPTH     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic [LANES*WEIGHT_BW-1:0]           load_data,
    input  logic                                 load_clear,
    input  logic                                 swap,
    output logic                                 swap_done,
    output logic                                 shadow_full,
    output logic                                 active_valid,
    output logic [$clog2(DEPTH)-1:0]             load_row,
    output logic [DEPTH*LANES*WEIGHT_BW-1:0]     weight_out
);

    localparam int ROW_W     = LANES * WEIGHT_BW;
    localparam int ROW_IDX_W = $clog2(DEPTH);
    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(DEPTH - 1);
    localparam logic [ROW_IDX_W-1:0] ROW_ZERO = ROW_IDX_W'(0);
    localparam logic [ROW_IDX_W-1:0] ROW_ONE  = ROW_IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_FULL = 2'b10
    } state_t;

    state_t                      state_r;
    logic [ROW_IDX_W-1:0]        load_row_r;
    logic                        load_ready_r;
    logic                        shadow_full_r;
    logic                        swap_done_r;
    logic                        active_valid_r;
    logic [ROW_W-1:0]            shadow_r [DEPTH];
    logic [DEPTH*ROW_W-1:0]      active_r;
    logic                        swap_take_s;
    logic                        accept_s;

`ifdef WEIGHT_BANK_AUTO_SWAP_EN
    // A full shadow bank is promoted on the very next edge regardless of swap.
    assign swap_take_s = 1'b1;
`else
    // Promotion happens only on an explicit swap request.
    assign swap_take_s = swap;
`endif

    // load_ready_r is low in FULL, so an accept can only happen in IDLE or LOAD.
    assign accept_s = load_valid & load_ready_r;

    // Load/swap state machine: shadow row writes, bank promotion and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            load_row_r     <= ROW_ZERO;
            load_ready_r   <= 1'b1;
            shadow_full_r  <= 1'b0;
            swap_done_r    <= 1'b0;
            active_valid_r <= 1'b0;
            active_r       <= '0;
            for (int r = 0; r < DEPTH; r++) begin
                shadow_r[r] <= '0;
            end
        end else begin
            swap_done_r <= 1'b0;
            if (load_clear) begin
                // Abandon the partial load; the active bank is left alone.
                state_r       <= ST_IDLE;
                load_row_r    <= ROW_ZERO;
                load_ready_r  <= 1'b1;
                shadow_full_r <= 1'b0;
            end else if ((state_r == ST_FULL) && swap_take_s) begin
                // Promote the whole shadow matrix in a single cycle.
                for (int r = 0; r < DEPTH; r++) begin
                    active_r[r*ROW_W +: ROW_W] <= shadow_r[r];
                end
                state_r        <= ST_IDLE;
                load_row_r     <= ROW_ZERO;
                load_ready_r   <= 1'b1;
                shadow_full_r  <= 1'b0;
                swap_done_r    <= 1'b1;
                active_valid_r <= 1'b1;
            end else if (accept_s) begin
                shadow_r[load_row_r] <= load_data;
                if (load_row_r == LAST_ROW) begin
                    // Last row: the bank is complete and stops accepting.
                    state_r       <= ST_FULL;
                    load_row_r    <= ROW_ZERO;
                    load_ready_r  <= 1'b0;
                    shadow_full_r <= 1'b1;
                end else begin
                    state_r       <= ST_LOAD;
                    load_row_r    <= load_row_r + ROW_ONE;
                    load_ready_r  <= 1'b1;
                    shadow_full_r <= 1'b0;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign load_ready   = load_ready_r;
    assign shadow_full  = shadow_full_r;
    assign load_row     = load_row_r;
    assign swap_done    = swap_done_r;
    assign active_valid = active_valid_r;
    assign weight_out   = active_r;

endmodule

// File: tb/tb_weight_bank_dbuf.sv
// Self-checking bench for weight_bank_dbuf: a table of directed beats, a few
// hand-written corner sequences and a randomized run, all compared against a
// row-count based reference model of the double-buffered store.
module tb_weight_bank_dbuf;

    localparam int WBW   = 8;
    localparam int LN    = 8;
    localparam int DP    = 8;
    localparam int ROW_W = LN * WBW;

    logic                    clk;
    logic                    rst;
    logic                    load_valid;
    logic                    load_ready;
    logic [ROW_W-1:0]        load_data;
    logic                    load_clear;
    logic                    swap;
    logic                    swap_done;
    logic                    shadow_full;
    logic                    active_valid;
    logic [2:0]              load_row;
    logic [DP*ROW_W-1:0]     weight_out;

    weight_bank_dbuf #(.WEIGHT_BW(WBW), .LANES(LN), .DEPTH(DP)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_clear  (load_clear),
        .swap        (swap),
        .swap_done   (swap_done),
        .shadow_full (shadow_full),
        .active_valid(active_valid),
        .load_row    (load_row),
        .weight_out  (weight_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: number of rows held, shadow rows, active rows.
    int               m_rows;
    logic [ROW_W-1:0] m_shadow [DP];
    logic [ROW_W-1:0] m_active [DP];
    logic             m_av;
    logic             m_done;

    typedef struct {
        logic             lv;
        logic             clr;
        logic             sw;
        logic [ROW_W-1:0] data;
        logic             e_ready;
        logic             e_full;
        logic [2:0]       e_row;
        logic             e_done;
        logic             e_av;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [DP*ROW_W-1:0] act, input logic [DP*ROW_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DP*ROW_W-1:0] model_flat();
        logic [DP*ROW_W-1:0] f;
        for (int r = 0; r < DP; r++) f[r*ROW_W +: ROW_W] = m_active[r];
        return f;
    endfunction

    function automatic logic [ROW_W-1:0] ramp_row(input int r);
        logic [ROW_W-1:0] d;
        for (int k = 0; k < LN; k++) d[k*WBW +: WBW] = WBW'(r * 8 + k);
        return d;
    endfunction

    task automatic model_reset();
        m_rows = 0;
        m_av   = 1'b0;
        m_done = 1'b0;
        for (int r = 0; r < DP; r++) begin
            m_shadow[r] = '0;
            m_active[r] = '0;
        end
    endtask

    task automatic model_step(input logic lv, input logic [ROW_W-1:0] d, input logic clr, input logic sw);
        logic take;
`ifdef WEIGHT_BANK_AUTO_SWAP_EN
        take = 1'b1;
`else
        take = sw;
`endif
        m_done = 1'b0;
        if (clr) begin
            m_rows = 0;
        end else if (m_rows == DP && take) begin
            for (int r = 0; r < DP; r++) m_active[r] = m_shadow[r];
            m_rows = 0;
            m_done = 1'b1;
            m_av   = 1'b1;
        end else if (lv && m_rows < DP) begin
            m_shadow[m_rows] = d;
            m_rows++;
        end
    endtask

    task automatic check_model();
        chk("load_ready",   32'(load_ready),   32'(m_rows < DP));
        chk("shadow_full",  32'(shadow_full),  32'(m_rows == DP));
        chk("load_row",     32'(load_row),     32'(m_rows % DP));
        chk("swap_done",    32'(swap_done),    32'(m_done));
        chk("active_valid", 32'(active_valid), 32'(m_av));
        chk_w("weight_out", weight_out, model_flat());
    endtask

    // One clock: drive after the falling edge, update model at the rising edge,
    // compare on the next falling edge.
    task automatic cycle(input logic lv, input logic [ROW_W-1:0] d, input logic clr, input logic sw);
        load_valid = lv;
        load_data  = d;
        load_clear = clr;
        swap       = sw;
        @(posedge clk);
        model_step(lv, d, clr, sw);
        @(negedge clk);
        check_model();
    endtask

    logic [ROW_W-1:0]    ones_row;
    logic [DP*ROW_W-1:0] ones_mat;
    logic [DP*ROW_W-1:0] first_mat;

    initial begin
        ones_row = '1;
        ones_mat = '1;
        rst = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_clear = 1'b0;
        swap       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Reset values.
        chk("rst_load_ready",   32'(load_ready),   32'd1);
        chk("rst_load_row",     32'(load_row),     32'd0);
        chk("rst_shadow_full",  32'(shadow_full),  32'd0);
        chk("rst_active_valid", 32'(active_valid), 32'd0);
        chk("rst_swap_done",    32'(swap_done),    32'd0);
        chk_w("rst_weight_out", weight_out, '0);

`ifndef WEIGHT_BANK_AUTO_SWAP_EN
        // Table: 12 beats of load_valid (8 accepted, 4 back-pressured), swap, idle.
        for (int i = 0; i < 12; i++) begin
            tbl[i].lv      = 1'b1;
            tbl[i].clr     = 1'b0;
            tbl[i].sw      = 1'b0;
            tbl[i].data    = ramp_row(i);
            tbl[i].e_ready = (i < 7) ? 1'b1 : 1'b0;
            tbl[i].e_full  = (i >= 7) ? 1'b1 : 1'b0;
            tbl[i].e_row   = (i < 7) ? 3'(i + 1) : 3'd0;
            tbl[i].e_done  = 1'b0;
            tbl[i].e_av    = 1'b0;
        end
        tbl[12] = '{lv: 1'b0, clr: 1'b0, sw: 1'b1, data: '0, e_ready: 1'b1,
                    e_full: 1'b0, e_row: 3'd0, e_done: 1'b1, e_av: 1'b1};
        tbl[13] = '{lv: 1'b0, clr: 1'b0, sw: 1'b0, data: '0, e_ready: 1'b1,
                    e_full: 1'b0, e_row: 3'd0, e_done: 1'b0, e_av: 1'b1};
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].lv, tbl[i].data, tbl[i].clr, tbl[i].sw);
            chk("tbl_ready",  32'(load_ready),   32'(tbl[i].e_ready));
            chk("tbl_full",   32'(shadow_full),  32'(tbl[i].e_full));
            chk("tbl_row",    32'(load_row),     32'(tbl[i].e_row));
            chk("tbl_done",   32'(swap_done),    32'(tbl[i].e_done));
            chk("tbl_av",     32'(active_valid), 32'(tbl[i].e_av));
        end
        chk("r3l5", 32'(weight_out[(3*8+5)*8 +: 8]), 32'd29);
        chk("r7l7", 32'(weight_out[(7*8+7)*8 +: 8]), 32'd63);
        first_mat = weight_out;

        // Second matrix of all -1 while the first one stays active.
        for (int i = 0; i < DP; i++) begin
            cycle(1'b1, ones_row, 1'b0, 1'b0);
            chk_w("hold_first", weight_out, first_mat);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk_w("all_ff", weight_out, ones_mat);

        // Swap in LOAD is ignored; clear with valid drops the row.
        for (int i = 0; i < 4; i++) cycle(1'b1, ramp_row(i + 20), 1'b0, 1'b0);
        chk("row4", 32'(load_row), 32'd4);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("ign_swap_done", 32'(swap_done), 32'd0);
        chk("ign_swap_row",  32'(load_row),  32'd4);
        cycle(1'b1, ramp_row(99), 1'b1, 1'b0);
        chk("clr_row",  32'(load_row),  32'd0);
        chk("clr_done", 32'(swap_done), 32'd0);
        chk_w("clr_keep", weight_out, ones_mat);

        // Last-row accept with swap: accepted, swap ignored; then clear beats swap.
        for (int i = 0; i < 7; i++) cycle(1'b1, ramp_row(i + 30), 1'b0, 1'b0);
        cycle(1'b1, ramp_row(37), 1'b0, 1'b1);
        chk("last_sw_full", 32'(shadow_full), 32'd1);
        chk("last_sw_done", 32'(swap_done),   32'd0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("clr_win_done", 32'(swap_done),   32'd0);
        chk("clr_win_full", 32'(shadow_full), 32'd0);
        chk_w("clr_win_keep", weight_out, ones_mat);
`else
        // Auto swap: last row at edge N, swap low, promotion at edge N+1.
        for (int i = 0; i < DP; i++) cycle(1'b1, ramp_row(i), 1'b0, 1'b0);
        chk("auto_full",  32'(shadow_full), 32'd1);
        chk("auto_done0", 32'(swap_done),   32'd0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("auto_done1", 32'(swap_done),   32'd1);
        chk("auto_r3l5",  32'(weight_out[(3*8+5)*8 +: 8]), 32'd29);
        // Clear at the auto-swap edge wins.
        for (int i = 0; i < DP; i++) cycle(1'b1, ones_row, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("auto_clr_done", 32'(swap_done), 32'd0);
        chk("auto_clr_r3l5", 32'(weight_out[(3*8+5)*8 +: 8]), 32'd29);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), ROW_W'({$urandom, $urandom}),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of a load, after a swap.
        while (m_rows != 0) cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DP; i++) cycle(1'b1, ramp_row(i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, ones_row, 1'b0, 1'b0);
        chk("pre_rst_row", 32'(load_row), 32'd5);
        chk("pre_rst_av",  32'(active_valid), 32'd1);
        load_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_row",   32'(load_row),     32'd0);
        chk("arst_av",    32'(active_valid), 32'd0);
        chk("arst_ready", 32'(load_ready),   32'd1);
        chk("arst_full",  32'(shadow_full),  32'd0);
        chk("arst_done",  32'(swap_done),    32'd0);
        chk_w("arst_wout", weight_out, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, ramp_row(i), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
